dmem_miss_ctrl: RTL and testbench

DMEM_MISS_CTRL -- requirements
Module: dmem_miss_ctrl

---
 rtl/dmem_miss_ctrl.sv | 120 ++++++++++++
 tb/tb_dmem_miss_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_miss_ctrl.sv
// dmem_miss_ctrl: two-lane data-cache miss controller; fetch timeout enabled by DMEM_MISS_TIMEOUT_EN
module dmem_miss_ctrl #(
    parameter int LINE_W  = 512,
    parameter int OFF_W   = 6,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc1,
    input  logic              acc2,
    input  logic              hit1,
    input  logic              hit2,
    input  logic [31:0]       addr1,
    input  logic [31:0]       addr2,
    input  logic              mem_ready,
    input  logic [LINE_W-1:0] mem_line,
    output logic              mem_req,
    output logic [31:0]       mem_addr,
    output logic              fill_en,
    output logic              fill_lane,
    output logic [LINE_W-1:0] fill_line,
    output logic              stallM,
    output logic              timeout_err
);
    typedef enum logic [2:0] {IDLE, FETCH1, FILL1, FETCH2, FILL2} state_e;
    state_e            state_q, state_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] fill_line_q, fill_line_d;
    logic              miss1, miss2, fetch, to_hit, unused_ok;
    logic [31-OFF_W:0] line1, line2;
    assign miss1     = acc1 & ~hit1;
    assign miss2     = acc2 & ~hit2;
    assign line1     = addr1[31:OFF_W];
    assign line2     = addr2[31:OFF_W];
    assign fetch     = (state_q == FETCH1) || (state_q == FETCH2);
    assign mem_req   = fetch;
    assign mem_addr  = mem_addr_q;
    assign fill_en   = (state_q == FILL1) || (state_q == FILL2);
    assign fill_lane = (state_q == FILL2);
    assign fill_line = fill_line_q;
    assign stallM    = (state_q != IDLE) || miss1 || miss2;
`ifdef DMEM_MISS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_err_q;
    assign to_hit      = fetch && !mem_ready && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign timeout_err = timeout_err_q;
    assign unused_ok   = ^{addr1[OFF_W-1:0], addr2[OFF_W-1:0]};
    // count FETCH cycles spent waiting; zero outside FETCH so every entry starts fresh
    always_comb cnt_d = (fetch && !mem_ready) ? cnt_q + 1'b1 : '0;
    // wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_q | to_hit;
        end
    end
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
    assign unused_ok   = ^{addr1[OFF_W-1:0], addr2[OFF_W-1:0], TIMEOUT};
`endif
    // next state: lane 1 first; a same-line lane 2 miss is satisfied by the lane 1 fill
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        fill_line_d = fill_line_q;
        case (state_q)
            IDLE: begin
                if (miss1) begin
                    state_d    = FETCH1;
                    mem_addr_d = {line1, {OFF_W{1'b0}}};
                end else if (miss2) begin
                    state_d    = FETCH2;
                    mem_addr_d = {line2, {OFF_W{1'b0}}};
                end
            end
            FETCH1: begin
                if (mem_ready) begin
                    state_d     = FILL1;
                    fill_line_d = mem_line;
                end else if (to_hit) begin
                    state_d = IDLE;
                end
            end
            FILL1: begin
                if (miss2 && (line2 != mem_addr_q[31:OFF_W])) begin
                    state_d    = FETCH2;
                    mem_addr_d = {line2, {OFF_W{1'b0}}};
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH2: begin
                if (mem_ready) begin
                    state_d     = FILL2;
                    fill_line_d = mem_line;
                end else if (to_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // state, request address and fill data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            fill_line_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            fill_line_q <= fill_line_d;
        end
    end
endmodule

// File: tb/tb_dmem_miss_ctrl.sv
// tb_dmem_miss_ctrl: directed and random checks of dmem_miss_ctrl against a transaction-level model
module tb_dmem_miss_ctrl;
`ifdef DMEM_MISS_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif
    logic         clk = 1'b0;
    logic         rst, acc1, acc2, hit1, hit2, mem_ready;
    logic [31:0]  addr1, addr2, mem_addr;
    logic [511:0] mem_line, fill_line;
    logic         mem_req, fill_en, fill_lane, stallM, timeout_err;
    int           total = 0;
    int           bad = 0;
    bit           cached [logic [25:0]];

    dmem_miss_ctrl #(.LINE_W(512), .OFF_W(6), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .acc1(acc1), .acc2(acc2), .hit1(hit1), .hit2(hit2),
        .addr1(addr1), .addr2(addr2), .mem_ready(mem_ready), .mem_line(mem_line),
        .mem_req(mem_req), .mem_addr(mem_addr), .fill_en(fill_en), .fill_lane(fill_lane),
        .fill_line(fill_line), .stallM(stallM), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] ldata(input logic [25:0] l);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = {l, 6'(i)} * 32'h9E37_79B1;
        return d;
    endfunction

    function automatic logic [511:0] rline();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic upd_hits();
        hit1 = cached.exists(addr1[31:6]);
        hit2 = cached.exists(addr2[31:6]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic a1, input logic a2,
                        input logic [31:0] ad1, input logic [31:0] ad2, input int lat);
        logic [25:0] exp_l[$];
        logic        exp_k[$];
        logic [25:0] pend;
        bit          pend_v, act, done, m1, m2;
        int          nreq, fills, fcyc, stalls, exp_stall, idx;
        pend_v = 0; act = 0; done = 0;
        nreq = 0; fills = 0; fcyc = 0; stalls = 0;
        m1 = a1 && !cached.exists(ad1[31:6]);
        m2 = a2 && !cached.exists(ad2[31:6]);
        if (m1) begin
            exp_l.push_back(ad1[31:6]);
            exp_k.push_back(1'b0);
        end
        if (m2 && !(m1 && ad2[31:6] == ad1[31:6])) begin
            exp_l.push_back(ad2[31:6]);
            exp_k.push_back(1'b1);
        end
        exp_stall = exp_l.size() == 0 ? 0 : 1 + exp_l.size() * (lat + 1);
        acc1 = a1; acc2 = a2; addr1 = ad1; addr2 = ad2; mem_ready = 1'b0;
        upd_hits();
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            #1;
            if (stallM) stalls++;
            if (mem_req) begin
                if (!act) begin
                    act = 1; fcyc = 0; nreq++;
                end
                fcyc++;
                if (nreq <= exp_l.size())
                    check({tag, "_mem_addr"}, 512'(mem_addr), 512'({exp_l[nreq-1], 6'b0}));
            end
            if (fill_en) begin
                act = 0;
                if (fills < exp_l.size()) begin
                    check({tag, "_fill_lane"}, 512'(fill_lane), 512'(exp_k[fills]));
                    check({tag, "_fill_line"}, fill_line, ldata(exp_l[fills]));
                    pend = exp_l[fills];
                    pend_v = 1;
                end
                fills++;
            end
            done = !stallM;
            tick();
            if (pend_v) begin
                cached[pend] = 1'b1;
                pend_v = 0;
            end
            upd_hits();
            mem_line = rline();
            idx = act ? nreq - 1 : nreq;
            if (mem_req) begin
                mem_ready = ((act ? fcyc + 1 : 1) == lat);
                if (idx < exp_l.size()) mem_line = ldata(exp_l[idx]);
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
        end
        check({tag, "_stall_cycles"}, 512'(stalls), 512'(exp_stall));
        check({tag, "_requests"}, 512'(nreq), 512'(exp_l.size()));
        check({tag, "_fills"}, 512'(fills), 512'(exp_l.size()));
        check({tag, "_timeout_err"}, 512'(timeout_err), 512'(0));
    endtask

    initial begin
        logic [25:0] l1, l2, ev;
        rst = 1; acc1 = 0; acc2 = 0; hit1 = 0; hit2 = 0;
        addr1 = 0; addr2 = 0; mem_ready = 0; mem_line = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", 512'(mem_req), 512'(0));
        check("rst_mem_addr", 512'(mem_addr), 512'(0));
        check("rst_fill_en", 512'(fill_en), 512'(0));
        check("rst_fill_lane", 512'(fill_lane), 512'(0));
        check("rst_fill_line", fill_line, 512'(0));
        check("rst_timeout_err", 512'(timeout_err), 512'(0));
        check("rst_stall", 512'(stallM), 512'(0));
        rst = 0;
        mem_ready = 1; mem_line = rline();
        #1;
        check("idle_ready_fill_en", 512'(fill_en), 512'(0));
        check("idle_ready_stall", 512'(stallM), 512'(0));
        tick();
        mem_ready = 0;
        #1;
        check("idle_ready_mem_req", 512'(mem_req), 512'(0));
        check("idle_ready_fill_en2", 512'(fill_en), 512'(0));
        check("idle_ready_fill_line", fill_line, 512'(0));
        check("idle_ready_stall2", 512'(stallM), 512'(0));
        tick();
        step("lane1_only", 1, 0, 32'h0000_1044, 32'h0, 3);
        step("both_lanes", 1, 1, 32'h0000_0100, 32'h0000_2000, 2);
        cached.delete();
        step("same_line", 1, 1, 32'h0000_0104, 32'h0000_013C, 4);
        step("lane2_only", 0, 1, 32'h0000_0104, 32'h0000_0A08, 1);
        step("all_hit", 1, 1, 32'h0000_0108, 32'h0000_0A3C, 1);
        cached.delete();
        acc1 = 1; acc2 = 0; addr1 = 32'h0000_0344; mem_ready = 0;
        upd_hits();
        tick();
        check("abort_req_before", 512'(mem_req), 512'(1));
        check("abort_addr_before", 512'(mem_addr), 512'(32'h340));
        tick();
        rst = 1; acc1 = 0; mem_ready = 1; mem_line = rline();
        upd_hits();
        tick();
        rst = 0; mem_ready = 0;
        #1;
        check("abort_mem_req", 512'(mem_req), 512'(0));
        check("abort_fill_en", 512'(fill_en), 512'(0));
        check("abort_stall", 512'(stallM), 512'(0));
        check("abort_mem_addr", 512'(mem_addr), 512'(0));
        tick();
        check("abort_fill_en_late", 512'(fill_en), 512'(0));
        check("abort_mem_req_late", 512'(mem_req), 512'(0));
        tick();
`ifdef DMEM_MISS_TIMEOUT_EN
        cached.delete();
        acc1 = 1; acc2 = 0; addr1 = 32'h0000_0500; mem_ready = 0;
        upd_hits();
        #1;
        check("to_idle_req", 512'(mem_req), 512'(0));
        for (int i = 0; i < 8; i++) begin
            tick();
            check("to_fetch_req", 512'(mem_req), 512'(1));
            check("to_fetch_err", 512'(timeout_err), 512'(0));
        end
        tick();
        check("to_drop_req", 512'(mem_req), 512'(0));
        check("to_err_set", 512'(timeout_err), 512'(1));
        check("to_drop_stall", 512'(stallM), 512'(1));
        tick();
        check("to_rerequest", 512'(mem_req), 512'(1));
        check("to_err_sticky", 512'(timeout_err), 512'(1));
        acc1 = 0; mem_ready = 1; mem_line = rline();
        upd_hits();
        tick();
        mem_ready = 0;
        #1;
        check("to_fill_en", 512'(fill_en), 512'(1));
        tick();
        check("to_idle_after", 512'(stallM), 512'(0));
        check("to_err_held", 512'(timeout_err), 512'(1));
        rst = 1;
        tick();
        rst = 0;
        #1;
        check("to_err_cleared", 512'(timeout_err), 512'(0));
        tick();
`else
        cached.delete();
        step("long_fetch", 1, 0, 32'h0000_07C0, 32'h0, 300);
`endif
        for (int n = 0; n < 80; n++) begin
            ev = 26'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0 && cached.exists(ev)) cached.delete(ev);
            l1 = 26'($urandom_range(0, 7));
            l2 = 26'($urandom_range(0, 7));
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 {l1, 6'($urandom_range(0, 63))}, {l2, 6'($urandom_range(0, 63))},
                 $urandom_range(1, 5));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
